// File: rtl/kb_input_ctrl_if.sv
// CPU-side bus of the PS/2 keyboard front end: pop/clr strobes in, packed kbin word and irq out.
interface kb_input_ctrl_if;
    logic        pop;
    logic        clr;
    logic [63:0] kbin;
    logic        irq;

    modport master (output pop, output clr, input kbin, input irq);
    modport slave  (input pop, input clr, output kbin, output irq);
endinterface

// File: rtl/kb_input_ctrl.sv
// PS/2 keyboard front end: sync, 11-bit frame deserialiser, scancode FIFO, packed kbin status word.
// Optional break-code filter enabled by defining KB_BREAK_FILTER_EN.
module kb_input_ctrl #(
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ps2_clk,
    input  logic             ps2_data,
    kb_input_ctrl_if.slave   bus
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

    // Sync chains reset to the idle-high bus level so release cannot fake a falling edge.
    logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
    logic                   ps2c_prev_q;
    logic                   ps2c, ps2d, fall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            ps2c_prev_q <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
            ps2c_prev_q <= ps2c;
        end
    end

    assign ps2c = clk_sync_q[SYNC_STAGES-1];
    assign ps2d = data_sync_q[SYNC_STAGES-1];
    assign fall = ps2c_prev_q & ~ps2c;

    state_e         state_q, state_d;
    logic [2:0]     bit_q, bit_d;
    logic [7:0]     shift_q, shift_d;
    logic           par_q, par_d;
    logic [TW-1:0]  to_cnt_q;
    logic           timeout, frame_good, frame_err;

    assign timeout = (state_q != StIdle) && !fall && (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d    = state_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        par_d      = par_q;
        frame_good = 1'b0;
        frame_err  = 1'b0;
        if (timeout) begin
            state_d   = StIdle;
            frame_err = 1'b1;
        end else if (fall) begin
            unique case (state_q)
                StIdle: begin
                    if (!ps2d) begin
                        state_d = StData;
                        bit_d   = 3'd0;
                    end
                end
                StData: begin
                    shift_d = {ps2d, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = StParity;
                end
                StParity: begin
                    par_d   = ps2d;
                    state_d = StStop;
                end
                StStop: begin
                    // Odd parity over data plus parity bit, and a high stop bit.
                    if (ps2d && (^{shift_q, par_q})) frame_good = 1'b1;
                    else                             frame_err  = 1'b1;
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            bit_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            to_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            if (state_q == StIdle || fall || timeout) to_cnt_q <= '0;
            else                                      to_cnt_q <= to_cnt_q + TW'(1);
        end
    end

    logic push;
`ifdef KB_BREAK_FILTER_EN
    // Drop 0xF0 and the byte that follows it so only make codes are queued.
    logic drop_q;
    assign push = frame_good && !drop_q && (shift_q != 8'hF0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_q <= 1'b0;
        end else if (frame_good) begin
            drop_q <= drop_q ? 1'b0 : (shift_q == 8'hF0);
        end
    end
`else
    assign push = frame_good;
`endif

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [4:0]    count_q;
    logic          ovf_q;
    logic [7:0]    err_q;
    logic          empty, full, do_pop, do_push;

    assign empty   = (count_q == 5'd0);
    assign full    = (count_q == 5'(FIFO_DEPTH));
    assign do_pop  = bus.pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            err_q   <= '0;
        end else begin
            if (do_push) begin
                mem_q[wptr_q] <= shift_q;
                wptr_q        <= wptr_q + AW'(1);
            end
            if (do_pop) rptr_q <= rptr_q + AW'(1);
            if (do_push && !do_pop)      count_q <= count_q + 5'd1;
            else if (do_pop && !do_push) count_q <= count_q - 5'd1;
            // clr takes priority over a coincident overflow or frame error.
            if (bus.clr)                   ovf_q <= 1'b0;
            else if (push && !do_push)     ovf_q <= 1'b1;
            if (bus.clr)                            err_q <= '0;
            else if (frame_err && err_q != 8'hFF)   err_q <= err_q + 8'd1;
        end
    end

    logic [7:0] head;
    assign head     = empty ? 8'h00 : mem_q[rptr_q];
    assign bus.kbin = {40'd0, err_q, 1'b0, ovf_q, count_q, !empty, head};
    assign bus.irq  = !empty;
endmodule

// File: tb/tb_kb_input_ctrl.sv
// Directed bench for kb_input_ctrl: bit-banged PS/2 frames against hand-computed kbin expectations.
module tb_kb_input_ctrl;
    localparam int unsigned Half = 4;

    logic clk = 1'b0;
    logic reset;
    logic ps2_clk;
    logic ps2_data;
    int   n_cmp = 0;
    int   n_mis = 0;

    kb_input_ctrl_if bus ();

    always #5 clk = ~clk;

    kb_input_ctrl #(
        .FIFO_DEPTH     (8),
        .SYNC_STAGES    (2),
        .TIMEOUT_CYCLES (300)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .bus      (bus.slave)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Every change happens on a negedge; pop_at_fall lines a pop up with the push edge.
    task automatic ps2_bit(input logic b, input logic pop_at_fall);
        ps2_data = b;
        wait_clks(Half);
        ps2_clk = 1'b0;
        if (pop_at_fall) begin
            wait_clks(2);
            bus.pop = 1'b1;
            wait_clks(1);
            bus.pop = 1'b0;
            wait_clks(Half - 3);
        end else begin
            wait_clks(Half);
        end
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop,
                              input logic pop_at_stop);
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i], 1'b0);
        ps2_bit((~^b) ^ bad_par, 1'b0);
        ps2_bit(stop, pop_at_stop);
        ps2_data = 1'b1;
        wait_clks(6);
    endtask

    task automatic pulse_pop();
        bus.pop = 1'b1;
        wait_clks(1);
        bus.pop = 1'b0;
        wait_clks(1);
    endtask

    task automatic pulse_clr();
        bus.clr = 1'b1;
        wait_clks(1);
        bus.clr = 1'b0;
        wait_clks(1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        bus.pop  = 1'b0;
        bus.clr  = 1'b0;
        #1;
        check("reset_kbin", bus.kbin, 64'h0);
        check("reset_irq", 64'(bus.irq), 64'h0);
        wait_clks(3);
        reset = 1'b0;
        wait_clks(3);

        // Single good frame then pop.
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        check("good_1c_kbin", bus.kbin, 64'h0000_0000_0000_031C);
        check("good_1c_irq", 64'(bus.irq), 64'h1);
        pulse_pop();
        check("pop_empty_kbin", bus.kbin, 64'h0);
        check("pop_empty_irq", 64'(bus.irq), 64'h0);

        // Bad parity, bad stop, then clr.
        send_frame(8'h29, 1'b1, 1'b1, 1'b0);
        check("bad_parity", bus.kbin, 64'h0000_0000_0001_0000);
        send_frame(8'h29, 1'b0, 1'b0, 1'b0);
        check("bad_stop", bus.kbin, 64'h0000_0000_0002_0000);
        pulse_clr();
        check("clr_err", bus.kbin, 64'h0);

        // Overflow: nine frames into an eight-deep FIFO.
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b1, 1'b0);
        check("ovf_occ", 64'(bus.kbin[13:9]), 64'd8);
        check("ovf_head", 64'(bus.kbin[7:0]), 64'h01);
        check("ovf_flag", 64'(bus.kbin[14]), 64'h1);
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("ovf_read_%0d", i), 64'(bus.kbin[7:0]), 64'(i));
            pulse_pop();
        end
        check("ovf_drained", 64'(bus.kbin[8]), 64'h0);
        pulse_clr();
        check("ovf_cleared", bus.kbin, 64'h0);

        // Full FIFO with a pop aligned to the ninth push.
        for (int i = 0; i < 8; i++) send_frame(8'h11 + 8'(i), 1'b0, 1'b1, 1'b0);
        send_frame(8'h19, 1'b0, 1'b1, 1'b1);
        check("align_ovf", 64'(bus.kbin[14]), 64'h0);
        check("align_occ", 64'(bus.kbin[13:9]), 64'd8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("align_read_%0d", i), 64'(bus.kbin[7:0]), 64'h12 + 64'(i));
            pulse_pop();
        end
        check("align_drained", bus.kbin, 64'h0);

        // Partial frame abandoned by timeout, then a clean frame.
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) ps2_bit(1'b1, 1'b0);
        wait_clks(400);
        check("timeout_err", bus.kbin, 64'h0000_0000_0001_0000);
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        check("after_timeout", bus.kbin, 64'h0000_0000_0001_031C);
        pulse_pop();
        pulse_clr();

        // Break-code sequence.
        send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
`ifdef KB_BREAK_FILTER_EN
        check("break_seq", bus.kbin, 64'h0000_0000_0000_031C);
`else
        check("break_seq", bus.kbin, 64'h0000_0000_0000_07F0);
`endif

        // Asynchronous reset in the middle of a frame.
        ps2_bit(1'b0, 1'b0);
        ps2_bit(1'b1, 1'b0);
        #3 reset = 1'b1;
        #1;
        check("midreset_kbin", bus.kbin, 64'h0);
        check("midreset_irq", 64'(bus.irq), 64'h0);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        wait_clks(3);
        reset = 1'b0;
        wait_clks(3);
        check("post_reset", bus.kbin, 64'h0);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
        check("post_reset_frame", bus.kbin, 64'h0000_0000_0000_035A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
